// File: rtl/adder_arbiter_if.sv
// Requester/response bundle for adder_arbiter: NREQ operand ports plus one result port.
interface adder_arbiter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;
  logic [IDW-1:0]        rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_id
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter time-multiplexing one ripple-carry adder among NREQ requesters,
// with a one-entry registered result buffer on a valid/ready response port.
module adder_arbiter_rca #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  logic [WIDTH:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[WIDTH];
endmodule

module adder_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  adder_arbiter_if.slave bus
);
  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [IDW-1:0]   r_id;

  logic             w_accept;
  logic             w_grant_vld;
  logic [IDW-1:0]   w_grant_idx;
  logic [IDW-1:0]   w_scan_idx;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_a_arr [NREQ];
  logic [WIDTH-1:0] w_b_arr [NREQ];

  for (genvar i = 0; i < int'(NREQ); i++) begin : g_unpack
    assign w_a_arr[i] = bus.req_a[i*WIDTH +: WIDTH];
    assign w_b_arr[i] = bus.req_b[i*WIDTH +: WIDTH];
  end

  // Reset gates accept so no requester is granted while rst_n is low.
  assign w_accept = rst_n && ((r_state == S_EMPTY) || bus.rsp_ready);

  // First valid requester at or above ptr, wrapping to 0.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_scan_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_scan_idx = IDW'((32'(r_ptr) + k) % NREQ);
      if (w_accept && !w_grant_vld && bus.req_valid[w_scan_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_scan_idx;
      end
    end
  end

  assign bus.req_ready = w_grant_vld ? (NREQ'(1) << w_grant_idx) : '0;
  assign w_ptr_nxt     = IDW'((32'(w_grant_idx) + 32'd1) % NREQ);

  assign w_a = w_a_arr[w_grant_idx];
  assign w_b = w_b_arr[w_grant_idx];

  adder_arbiter_rca #(.WIDTH(WIDTH)) u_rca (
    .i_a    (w_a),
    .i_b    (w_b),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_carry)
  );

  // A grant always refills the buffer, so it also covers the pop-and-refill case.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_grant_vld) w_state_nxt = S_FULL;
      S_FULL: begin
        if (w_grant_vld)        w_state_nxt = S_FULL;
        else if (bus.rsp_ready) w_state_nxt = S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_id    <= '0;
    end else if (w_grant_vld) begin
      r_ptr   <= w_ptr_nxt;
      r_sum   <= w_sum;
      r_carry <= w_carry;
      r_id    <= w_grant_idx;
    end
  end

  assign bus.rsp_valid = (r_state == S_FULL);
  assign bus.rsp_sum   = r_sum;
  assign bus.rsp_carry = r_carry;
  assign bus.rsp_id    = r_id;
endmodule
